imem_burst_fetch: RTL and testbench



---
 rtl/imem_burst_fetch_if.sv | 34 +++
 rtl/imem_burst_fetch.sv | 115 +++++++++++
 tb/tb_imem_burst_fetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_burst_fetch_if.sv
// Bundles the request, response and program-load write signals of imem_burst_fetch.
// The DUT takes the slave modport and the requester side takes the master modport.
interface imem_burst_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_last;
    logic              rsp_oob;
    logic              rsp_perr;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output req_valid, req_addr, req_len, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_oob, rsp_perr
    );

    modport slave (
        input  req_valid, req_addr, req_len, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_oob, rsp_perr
    );
endinterface

// File: rtl/imem_burst_fetch.sv
// Instruction memory with burst read port and single-cycle program-load write port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
//
// state | meaning
// IDLE  | ready for a request; no word issues
// BURST | issuing one word per cycle whenever the response slot is free
module imem_burst_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    imem_burst_fetch_if.slave   bus
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  count;
    logic              accept, issue;
    logic              wr_ok, wr_hit, rd_oob;
    logic [DATA_W-1:0] rd_word;

    assign wr_ok  = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_L);
    assign wr_hit = wr_ok && (bus.wr_addr == addr);
    assign rd_oob = ({1'b0, addr} >= DEPTH_L);

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        issue         = 1'b0;
        bus.req_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                accept        = bus.req_valid;
                if (accept) state_nxt = BURST;
            end
            BURST: begin
                issue = !bus.rsp_valid || bus.rsp_ready;
                if (issue && (count == '0)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write-first: a same-cycle write to the issuing address is forwarded.
    always_comb begin
        rd_word = '0;
        if (!rd_oob) rd_word = wr_hit ? bus.wr_data : mem[addr];
    end

    always_ff @(posedge clock) begin
        if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            count         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_addr  <= '0;
            bus.rsp_last  <= 1'b0;
            bus.rsp_oob   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr  <= bus.req_addr;
                count <= bus.req_len;
            end
            if (issue) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= rd_word;
                bus.rsp_addr  <= addr;
                bus.rsp_last  <= (count == '0);
                bus.rsp_oob   <= rd_oob;
                addr          <= addr + 1'b1;
                count         <= count - 1'b1;
            end else if (bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic par [DEPTH] = '{default: 1'b0};
    logic rd_perr, perr_q;

    always_comb begin
        rd_perr = 1'b0;
        if (!rd_oob && !wr_hit) rd_perr = (par[addr] != ^mem[addr]);
    end

    always_ff @(posedge clock) begin
        if (wr_ok) par[bus.wr_addr] <= ^bus.wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      perr_q <= 1'b0;
        else if (issue) perr_q <= rd_perr;
    end

    assign bus.rsp_perr = perr_q;
`else
    assign bus.rsp_perr = 1'b0;
`endif
endmodule

// File: tb/tb_imem_burst_fetch.sv
// Directed bench for imem_burst_fetch: a default-depth instance and a DEPTH=200 instance
// driven by identical stimulus; inputs change and outputs are sampled on the falling edge.
module tb_imem_burst_fetch;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = 4;

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          rsp_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int n_chk = 0;
    int n_err = 0;
    int n_xfer = 0;
    int xfer0;

    imem_burst_fetch_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus_a ();
    imem_burst_fetch_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus_b ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_len   = req_len;
    assign bus_a.rsp_ready = rsp_ready;
    assign bus_a.wr_en     = wr_en;
    assign bus_a.wr_addr   = wr_addr;
    assign bus_a.wr_data   = wr_data;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_len   = req_len;
    assign bus_b.rsp_ready = rsp_ready;
    assign bus_b.wr_en     = wr_en;
    assign bus_b.wr_addr   = wr_addr;
    assign bus_b.wr_data   = wr_data;

    imem_burst_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .LEN_W(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    imem_burst_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .LEN_W(LW)) dut200 (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && bus_a.rsp_valid && bus_a.rsp_ready) n_xfer <= n_xfer + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic last);
        chk({tag, ".valid"}, 64'(bus_a.rsp_valid), 64'd1);
        chk({tag, ".addr"},  64'(bus_a.rsp_addr),  64'(a));
        chk({tag, ".data"},  64'(bus_a.rsp_data),  64'(d));
        chk({tag, ".last"},  64'(bus_a.rsp_last),  64'(last));
        chk({tag, ".oob"},   64'(bus_a.rsp_oob),   64'd0);
        chk({tag, ".perr"},  64'(bus_a.rsp_perr),  64'd0);
    endtask

    task automatic chk_b(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic last, input logic oob);
        chk({tag, ".b.valid"}, 64'(bus_b.rsp_valid), 64'd1);
        chk({tag, ".b.addr"},  64'(bus_b.rsp_addr),  64'(a));
        chk({tag, ".b.data"},  64'(bus_b.rsp_data),  64'(d));
        chk({tag, ".b.last"},  64'(bus_b.rsp_last),  64'(last));
        chk({tag, ".b.oob"},   64'(bus_b.rsp_oob),   64'(oob));
    endtask

    task automatic mem_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // Returns at the falling edge after acceptance; first word is visible one edge later.
    task automatic request(input logic [AW-1:0] a, input logic [LW-1:0] len);
        req_valid = 1'b1; req_addr = a; req_len = len;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    logic [DW-1:0] wrap_data [4] = '{32'h0, 32'hA5A5_0001, 32'h0000_1234, 32'h0};
    logic [AW-1:0] wa;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        rsp_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clock);
        chk("rst.valid", 64'(bus_a.rsp_valid), 64'd0);
        chk("rst.data",  64'(bus_a.rsp_data),  64'd0);
        chk("rst.addr",  64'(bus_a.rsp_addr),  64'd0);
        chk("rst.last",  64'(bus_a.rsp_last),  64'd0);
        chk("rst.oob",   64'(bus_a.rsp_oob),   64'd0);
        chk("rst.perr",  64'(bus_a.rsp_perr),  64'd0);
        chk("rst.ready", 64'(bus_a.req_ready), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        // single-word burst
        mem_wr(8'd2, 32'h7104_1000);
        chk("single.ready_idle", 64'(bus_a.req_ready), 64'd1);
        request(8'd2, 4'd0);
        chk("single.lat_valid", 64'(bus_a.rsp_valid), 64'd0);
        chk("single.ready_busy", 64'(bus_a.req_ready), 64'd0);
        @(negedge clock);
        chk_a("single", 8'd2, 32'h7104_1000, 1'b1);
        chk("single.ready_back", 64'(bus_a.req_ready), 64'd1);
        @(negedge clock);
        chk("single.drain", 64'(bus_a.rsp_valid), 64'd0);

        // address wrap 254,255,0,1
        mem_wr(8'd255, 32'hA5A5_0001);
        mem_wr(8'd0,   32'h0000_1234);
        request(8'd254, 4'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            wa = AW'(254 + i);
            chk_a($sformatf("wrap%0d", i), wa, wrap_data[i], i == 3);
            chk_b($sformatf("wrap%0d", i), wa, (wa >= 8'd200) ? 32'h0 : wrap_data[i],
                  i == 3, wa >= 8'd200);
        end
        @(negedge clock);
        chk("wrap.drain", 64'(bus_a.rsp_valid), 64'd0);
        chk("wrap.ready", 64'(bus_a.req_ready), 64'd1);

        // backpressure on the first word
        mem_wr(8'd10, 32'h1000_000A);
        mem_wr(8'd11, 32'h1000_000B);
        mem_wr(8'd12, 32'h1000_000C);
        xfer0 = n_xfer;
        request(8'd10, 4'd2);
        @(negedge clock);
        chk_a("bp.w0", 8'd10, 32'h1000_000A, 1'b0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_a($sformatf("bp.hold%0d", i), 8'd10, 32'h1000_000A, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk_a("bp.w1", 8'd11, 32'h1000_000B, 1'b0);
        @(negedge clock);
        chk_a("bp.w2", 8'd12, 32'h1000_000C, 1'b1);
        @(negedge clock);
        chk("bp.drain", 64'(bus_a.rsp_valid), 64'd0);
        chk("bp.count", 64'(n_xfer - xfer0), 64'd3);

        // depth boundary on the DEPTH=200 instance
        mem_wr(8'd199, 32'hC0FF_EE99);
        mem_wr(8'd250, 32'h0000_DEAD);
        request(8'd199, 4'd1);
        @(negedge clock);
        chk_b("oob.w0", 8'd199, 32'hC0FF_EE99, 1'b0, 1'b0);
        @(negedge clock);
        chk_b("oob.w1", 8'd200, 32'h0, 1'b1, 1'b1);
        @(negedge clock);
        request(8'd250, 4'd0);
        @(negedge clock);
        chk_a("oob.a250", 8'd250, 32'h0000_DEAD, 1'b1);
        chk_b("oob.b250", 8'd250, 32'h0, 1'b1, 1'b1);
        @(negedge clock);

        // write-first collision
        mem_wr(8'd5, 32'h0000_0055);
        request(8'd5, 4'd0);
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'h0000_5A5A;
        @(negedge clock);
        wr_en = 1'b0;
        chk_a("wfirst", 8'd5, 32'h0000_5A5A, 1'b1);
        @(negedge clock);

        // reset mid-burst
        request(8'd20, 4'd7);
        @(negedge clock);
        chk("abort.pre", 64'(bus_a.rsp_addr), 64'd20);
        reset = 1'b1;
        #1;
        chk("abort.valid", 64'(bus_a.rsp_valid), 64'd0);
        chk("abort.addr",  64'(bus_a.rsp_addr),  64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort.ready", 64'(bus_a.req_ready), 64'd1);
        @(negedge clock);
        chk("abort.quiet", 64'(bus_a.rsp_valid), 64'd0);
        request(8'd2, 4'd0);
        @(negedge clock);
        chk_a("retain", 8'd2, 32'h7104_1000, 1'b1);
        @(negedge clock);

`ifdef IMEM_PARITY_EN
        mem_wr(8'd7, 32'h0000_0003);
        dut.mem[7] = dut.mem[7] ^ 32'h0000_0001;
        request(8'd7, 4'd0);
        @(negedge clock);
        chk("par.flip", 64'(bus_a.rsp_perr), 64'd1);
        @(negedge clock);
        request(8'd12, 4'd0);
        @(negedge clock);
        chk("par.clean", 64'(bus_a.rsp_perr), 64'd0);
        @(negedge clock);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
